// File: rtl/dhvajanka_pkg.sv
// -----------------------------------------------------------------------------
// dhvajanka_pkg
// Shared definitions for the dhvajanka_prep divisor pre-analysis block:
//   - state_e        : FSM state encoding (also exported on the debug port)
//   - POW10_LO/HI    : the two candidate bases (10 and 100)
//   - DIVISOR_MAX    : largest divisor the compute stage accepts
//   - TIMEOUT_W      : width of the optional WAIT watchdog counter
//   - ARITH_W        : working width for the distance / classify arithmetic
//   - abs_dist()     : unsigned absolute difference helper
// -----------------------------------------------------------------------------
package dhvajanka_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEARCH0  = 3'd1,
        ST_SEARCH1  = 3'd2,
        ST_CLASSIFY = 3'd3,
        ST_LAUNCH   = 3'd4,
        ST_WAIT     = 3'd5
    } state_e;

    localparam int unsigned POW10_LO    = 10;
    localparam int unsigned POW10_HI    = 100;
    localparam int unsigned DIVISOR_MAX = 255;
    localparam int unsigned TIMEOUT_W   = 6;

    // 12 bits holds 10 * 245 (largest distance times ten) without overflow.
    localparam int unsigned ARITH_W     = 12;

    function automatic logic [ARITH_W-1:0] abs_dist(
        input logic [ARITH_W-1:0] a,
        input logic [ARITH_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/dhvajanka_prep.sv
// -----------------------------------------------------------------------------
// dhvajanka_prep
// Divisor pre-analysis stage in front of an iterative divider. On an accepted
// start it latches the operands, picks whichever power of ten (10 or 100) is
// closest to the divisor (ties go to 100), derives an iteration budget from
// how far the divisor is from that base, then launches the compute stage and
// waits for it to finish.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-high reset
//   start           in   request, only looked at in IDLE
//   dividend[15:0]  in   dividend forwarded to the compute stage
//   divisor[15:0]   in   unsigned divisor, valid range 1..255
//   comp_done       in   completion pulse from the compute stage
//   comp_start      out  one-cycle launch pulse
//   dividend_out    out  latched dividend
//   divisor_out     out  latched divisor
//   power10_value   out  chosen base (10 or 100)
//   difference      out  signed base minus divisor (9 bits)
//   max_iterations  out  iteration budget (1, 3, 5 or 7)
//   busy            out  high whenever the FSM is not in IDLE
//   err             out  sticky error (bad divisor, or watchdog expiry)
//   fsm_state       out  current FSM state, for debug/checkers
//
// Handshake with the compute stage: comp_start is a single-cycle pulse issued
// from LAUNCH; the operands and analysis outputs are stable from that cycle
// until the FSM is back in IDLE (and beyond, until the next accepted start).
// comp_done is a pulse that is only honoured while in WAIT; anywhere else it
// is dropped. start is only honoured in IDLE and is never queued.
//
// Build option: define DHVAJANKA_PREP_TIMEOUT_EN to add a 6-bit watchdog in
// WAIT that raises err and returns to IDLE after 63 cycles without comp_done.
// -----------------------------------------------------------------------------
module dhvajanka_prep
    import dhvajanka_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       dividend,
    input  logic [15:0]       divisor,
    input  logic              comp_done,
    output logic              comp_start,
    output logic [15:0]       dividend_out,
    output logic [15:0]       divisor_out,
    output logic [7:0]        power10_value,
    output logic signed [8:0] difference,
    output logic [2:0]        max_iterations,
    output logic              busy,
    output logic              err,
    output state_e            fsm_state
);

    localparam logic [7:0]         BASE_LO  = 8'(POW10_LO);
    localparam logic [7:0]         BASE_HI  = 8'(POW10_HI);
    localparam logic [ARITH_W-1:0] TEN      = ARITH_W'(10);

    state_e state;
    state_e state_nxt;

    // Running best candidate between SEARCH0 and CLASSIFY.
    logic [7:0]         best_base;
    logic [ARITH_W-1:0] best_dist;

    logic               in_range;
    logic [ARITH_W-1:0] div_w;
    logic [ARITH_W-1:0] dist_lo;
    logic [ARITH_W-1:0] dist_hi;
    logic [9:0]         diff10;
    logic [ARITH_W-1:0] dist_x10;
    logic [ARITH_W-1:0] dist_x2;
    logic [ARITH_W-1:0] base_w;
    logic [2:0]         iter_class;
    logic               timeout_hit;

    // ------------------------------------------------------------------
    // Combinational analysis
    // ------------------------------------------------------------------
    assign in_range = (divisor != 16'd0) && (divisor <= 16'(DIVISOR_MAX));

    // The latched divisor is known to be <= 255 whenever the search states
    // run, so the low ARITH_W bits carry its full value.
    assign div_w   = divisor_out[ARITH_W-1:0];
    assign dist_lo = abs_dist(ARITH_W'(POW10_LO), div_w);
    assign dist_hi = abs_dist(ARITH_W'(POW10_HI), div_w);

    // Signed 10-bit base - divisor; the low 9 bits cover -155..+99.
    assign diff10  = {2'b00, best_base} - divisor_out[9:0];

    assign dist_x10 = best_dist * TEN;
    assign dist_x2  = best_dist << 1;
    assign base_w   = ARITH_W'(best_base);

    // First matching rule wins: exact hit, within 10 %, within half, else far.
    always_comb begin
        iter_class = 3'd7;
        if (best_dist == '0) begin
            iter_class = 3'd1;
        end else if (dist_x10 <= base_w) begin
            iter_class = 3'd3;
        end else if (dist_x2 < base_w) begin
            iter_class = 3'd5;
        end
    end

    // ------------------------------------------------------------------
    // Optional WAIT watchdog
    // ------------------------------------------------------------------
`ifdef DHVAJANKA_PREP_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wait_cnt;

    // Loaded with 1 on the way into WAIT so that the counter equals the
    // number of the WAIT cycle in progress; all-ones marks the 63rd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ST_LAUNCH) begin
            wait_cnt <= TIMEOUT_W'(1);
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + TIMEOUT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // comp_done in the expiry cycle takes priority over the timeout.
    assign timeout_hit = (state == ST_WAIT) && !comp_done && (&wait_cnt);
`else
    assign timeout_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start && in_range) begin
                    state_nxt = ST_SEARCH0;
                end
            end
            ST_SEARCH0:  state_nxt = ST_SEARCH1;
            ST_SEARCH1:  state_nxt = ST_CLASSIFY;
            ST_CLASSIFY: state_nxt = ST_LAUNCH;
            ST_LAUNCH:   state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (comp_done || timeout_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:     state_nxt = ST_IDLE;
        endcase
    end

    assign comp_start = (state == ST_LAUNCH);
    assign busy       = (state != ST_IDLE);
    assign fsm_state  = state;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dividend_out   <= '0;
            divisor_out    <= '0;
            power10_value  <= '0;
            difference     <= '0;
            max_iterations <= '0;
            err            <= 1'b0;
            best_base      <= '0;
            best_dist      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dividend_out <= dividend;
                        divisor_out  <= divisor;
                        err          <= !in_range;
                    end
                end
                ST_SEARCH0: begin
                    best_base <= BASE_LO;
                    best_dist <= dist_lo;
                end
                ST_SEARCH1: begin
                    // <= so that an equal distance hands the tie to 100.
                    if (dist_hi <= best_dist) begin
                        best_base <= BASE_HI;
                        best_dist <= dist_hi;
                    end
                end
                ST_CLASSIFY: begin
                    power10_value  <= best_base;
                    difference     <= diff10[8:0];
                    max_iterations <= iter_class;
                end
                ST_WAIT: begin
                    if (timeout_hit) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
